surf6_fwu_writer: RTL and testbench
===================================

// Module: surf6_fwu_writer
// PURPOSE
//  Upstream feeder of the firmware-update marker. Accepts firmware bytes and "mark" requests
//  from the command decoder (sysclk), writes bytes into a 2-bank ping-pong BRAM, and on mark
//  issues the 1-cycle mark pulse and write-activity pulse that the marker consumes.
//  Holds a mark until the PS has released the previous bank (marker GPO low), then flips bank.
// PARAMETERS
//  BANK_AW   12   address bits per bank; bank depth = 2**BANK_AW bytes
// PORTS
//  sysclk_i        in   1          system clock; the only clock
//  sysrst_n_i      in   1          asynchronous, active-low reset
//  fw_dat_i        in   8          firmware byte from command decoder
//  fw_dat_valid_i  in   1          fw_dat_i valid this cycle (no backpressure)
//  fw_mark_req_i   in   1          1-cycle request: close current bank, hand to PS
//  fw_pending_i    in   1          marker GPO level (PS still owns last marked bank)
//  bram_we_o       out  1          BRAM write strobe
//  bram_addr_o     out  BANK_AW+1  {bank, offset}
//  bram_dat_o      out  8          BRAM write data
//  fw_wr_o         out  1          1-cycle pulse per accepted byte (to marker fw_wr_i)
//  fw_mark_o       out  1          1-cycle pulse when bank handed over (to marker fw_mark_i)
//  fw_bank_o       out  1          bank currently being filled
//  fw_len_o        out  BANK_AW+1  byte count of last marked bank (1..2**BANK_AW)
//  fw_overflow_o   out  1          sticky: byte dropped (bank full or MARK_WAIT)
//  fw_markerr_o    out  1          sticky: mark request with empty bank
// BEHAVIOUR
//  Reset (async assert, sync release): state FILL, bank 0, count 0, all outputs 0.
//  count is BANK_AW+1 bits (range 0..2**BANK_AW).
//  FSM: FILL -> (mark req, count>0) -> MARK_WAIT -> (!fw_pending_i) -> MARK -> FILL.
//   FILL: valid byte with count<2**BANK_AW: registered write next cycle,
//     bram_addr_o={bank,count[BANK_AW-1:0]}, bram_we_o=1, fw_wr_o=1; count++.
//     Valid byte with count==2**BANK_AW: dropped, fw_overflow_o set, no fw_wr_o.
//   Mark with count==0: ignored, fw_markerr_o set, stay FILL.
//   Byte and mark same cycle: byte accepted first and counted in fw_len_o.
//   MARK_WAIT: bytes dropped and set fw_overflow_o; further mark reqs ignored (no error).
//     Exits the cycle after fw_pending_i is sampled low; may be the entry cycle's successor.
//   MARK: fw_mark_o=1 for exactly one cycle; fw_len_o<=count; bank toggles; count<=0.
//     A byte in this cycle is dropped + overflow; next byte goes to new bank offset 0.
//  Latency: byte in cycle N -> bram_we_o/fw_wr_o in N+1. Mark with pending low: MARK_WAIT
//   in N+1, fw_mark_o in N+2.
//  fw_pending_i rises 1 cycle after fw_mark_o; MARK_WAIT never samples that stale low
//   because a new mark needs >=1 byte first.
//  Sticky flags clear only on reset. Reset mid-MARK_WAIT: mark discarded, bank 0.
// STRUCTURE
//  surf6_fwu_pkg: state enum typedef (FILL, MARK_WAIT, MARK), FWU_DAT_W=8.
//  Single module; no sub-module (one counter, one 3-state FSM, write-port registers).
// TESTING
//  1) Reset, write 5 bytes 0xA0..0xA4 -> addr 0x000..0x004 bank0, 5 fw_wr_o pulses.
//  2) Then mark, pending low -> fw_mark_o 2 cycles later, fw_len_o=5, fw_bank_o=1,
//     next byte at addr 0x1000 (BANK_AW=12).
//  3) Mark with pending high 20 cycles, bytes sent meanwhile -> no fw_mark_o until
//     pending falls; bytes dropped, fw_overflow_o=1.
//  4) Fill 4096 bytes, send a 4097th -> no write, overflow=1; mark -> fw_len_o=4096.
//  5) Mark right after reset -> fw_markerr_o=1, no fw_mark_o. Byte+mark same cycle
//     -> byte written, fw_len_o=1.
//  6) Assert sysrst_n_i low in MARK_WAIT -> outputs 0 at once; no fw_mark_o after release.

Source files
------------

// File: rtl/surf6_fwu_pkg.sv
// Shared types for the firmware-update writer: FSM state encoding and byte width.
package surf6_fwu_pkg;

    localparam int FWU_DAT_W = 8;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        MARK_WAIT = 2'd1,
        MARK      = 2'd2
    } fwu_state_t;

endpackage

// File: rtl/surf6_fwu_writer.sv
// Firmware-update writer: fills a 2-bank ping-pong BRAM from the command decoder and
// hands a filled bank to the PS with a one-cycle mark pulse once the PS has released the previous one.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------------
//   FILL      | accepting bytes into the current bank; mark request closes it
//   MARK_WAIT | bank closed, waiting for the PS to drop fw_pending_i; bytes dropped
//   MARK      | one-cycle handover: fw_mark_o high, new bank active, bytes dropped
module surf6_fwu_writer
    import surf6_fwu_pkg::*;
#(
    parameter int BANK_AW = 12
) (
    input  logic                 sysclk_i,
    input  logic                 sysrst_n_i,
    input  logic [FWU_DAT_W-1:0] fw_dat_i,
    input  logic                 fw_dat_valid_i,
    input  logic                 fw_mark_req_i,
    input  logic                 fw_pending_i,
    output logic                 bram_we_o,
    output logic [BANK_AW:0]     bram_addr_o,
    output logic [FWU_DAT_W-1:0] bram_dat_o,
    output logic                 fw_wr_o,
    output logic                 fw_mark_o,
    output logic                 fw_bank_o,
    output logic [BANK_AW:0]     fw_len_o,
    output logic                 fw_overflow_o,
    output logic                 fw_markerr_o
);

    fwu_state_t         state;
    logic [BANK_AW:0]   count;
    logic               bank_full;
    logic               byte_ok;

    // count saturates at exactly 2**BANK_AW, so its MSB alone flags a full bank
    assign bank_full = count[BANK_AW];
    assign byte_ok   = (state == FILL) && fw_dat_valid_i && !bank_full;

    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            state         <= FILL;
            count         <= '0;
            bram_we_o     <= 1'b0;
            bram_addr_o   <= '0;
            bram_dat_o    <= '0;
            fw_wr_o       <= 1'b0;
            fw_mark_o     <= 1'b0;
            fw_bank_o     <= 1'b0;
            fw_len_o      <= '0;
            fw_overflow_o <= 1'b0;
            fw_markerr_o  <= 1'b0;
        end else begin
            bram_we_o <= 1'b0;
            fw_wr_o   <= 1'b0;
            fw_mark_o <= 1'b0;
            case (state)
                FILL: begin
                    if (byte_ok) begin
                        bram_we_o   <= 1'b1;
                        fw_wr_o     <= 1'b1;
                        bram_addr_o <= {fw_bank_o, count[BANK_AW-1:0]};
                        bram_dat_o  <= fw_dat_i;
                        count       <= count + 1'b1;
                    end else if (fw_dat_valid_i) begin
                        fw_overflow_o <= 1'b1;
                    end
                    // a byte arriving with the mark is already part of the closed bank
                    if (fw_mark_req_i) begin
                        if ((count != '0) || byte_ok) begin
                            state <= MARK_WAIT;
                        end else begin
                            fw_markerr_o <= 1'b1;
                        end
                    end
                end
                MARK_WAIT: begin
                    if (fw_dat_valid_i) begin
                        fw_overflow_o <= 1'b1;
                    end
                    // length and new bank are presented together with the mark pulse
                    if (!fw_pending_i) begin
                        state     <= MARK;
                        fw_mark_o <= 1'b1;
                        fw_len_o  <= count;
                        fw_bank_o <= ~fw_bank_o;
                        count     <= '0;
                    end
                end
                MARK: begin
                    if (fw_dat_valid_i) begin
                        fw_overflow_o <= 1'b1;
                    end
                    state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_surf6_fwu_writer.sv
// Scoreboard bench for surf6_fwu_writer: expected BRAM writes and mark handovers are
// queued when stimulus is driven and popped when the writer produces them.
module tb_surf6_fwu_writer;
    import surf6_fwu_pkg::*;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic           sysclk_i = 1'b0;
    logic           sysrst_n_i = 1'b0;
    logic [7:0]     fw_dat_i = '0;
    logic           fw_dat_valid_i = 1'b0;
    logic           fw_mark_req_i = 1'b0;
    logic           fw_pending_i = 1'b0;
    logic           bram_we_o;
    logic [AW:0]    bram_addr_o;
    logic [7:0]     bram_dat_o;
    logic           fw_wr_o;
    logic           fw_mark_o;
    logic           fw_bank_o;
    logic [AW:0]    fw_len_o;
    logic           fw_overflow_o;
    logic           fw_markerr_o;

    surf6_fwu_writer #(.BANK_AW(AW)) dut (
        .sysclk_i       (sysclk_i),
        .sysrst_n_i     (sysrst_n_i),
        .fw_dat_i       (fw_dat_i),
        .fw_dat_valid_i (fw_dat_valid_i),
        .fw_mark_req_i  (fw_mark_req_i),
        .fw_pending_i   (fw_pending_i),
        .bram_we_o      (bram_we_o),
        .bram_addr_o    (bram_addr_o),
        .bram_dat_o     (bram_dat_o),
        .fw_wr_o        (fw_wr_o),
        .fw_mark_o      (fw_mark_o),
        .fw_bank_o      (fw_bank_o),
        .fw_len_o       (fw_len_o),
        .fw_overflow_o  (fw_overflow_o),
        .fw_markerr_o   (fw_markerr_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // expected writes {addr, data} and marks {new bank, len}
    logic [20:0] wr_q[$];
    logic [13:0] mk_q[$];

    int cyc = 0;
    int wr_cnt = 0;
    int mark_cnt = 0;
    int last_mark_cyc = 0;

    always @(posedge sysclk_i) cyc <= cyc + 1;

    always @(negedge sysclk_i) begin
        if (sysrst_n_i) begin
            if (bram_we_o || fw_wr_o) begin
                logic [20:0] ew;
                check_val("wr_pulse_pair", {31'd0, fw_wr_o}, {31'd0, bram_we_o});
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check_val("wr_unexpected_qsize", wr_q.size(), 1);
                end else begin
                    ew = wr_q.pop_front();
                    check_val("wr_addr", {19'd0, bram_addr_o}, {19'd0, ew[20:8]});
                    check_val("wr_dat", {24'd0, bram_dat_o}, {24'd0, ew[7:0]});
                end
            end
            if (fw_mark_o) begin
                logic [13:0] em;
                mark_cnt++;
                last_mark_cyc = cyc;
                if (mk_q.size() == 0) begin
                    check_val("mark_unexpected_qsize", mk_q.size(), 1);
                end else begin
                    em = mk_q.pop_front();
                    check_val("mark_bank", {31'd0, fw_bank_o}, {31'd0, em[13]});
                    check_val("mark_len", {19'd0, fw_len_o}, {19'd0, em[12:0]});
                end
            end
        end
    end

    // bench model of the writer's bank/count state
    logic m_bank = 1'b0;
    int   m_cnt = 0;
    logic m_wait = 1'b0;

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic model_clear();
        m_bank = 1'b0;
        m_cnt  = 0;
        m_wait = 1'b0;
        wr_q.delete();
        mk_q.delete();
    endtask

    task automatic do_reset();
        @(posedge sysclk_i);
        #1 sysrst_n_i = 1'b0;
        fw_dat_valid_i = 1'b0;
        fw_mark_req_i  = 1'b0;
        model_clear();
        tick();
        tick();
        sysrst_n_i = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d);
        if (!m_wait && m_cnt < DEPTH) begin
            wr_q.push_back({m_bank, m_cnt[AW-1:0], d});
            m_cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        push_byte(d);
        fw_dat_i       = d;
        fw_dat_valid_i = 1'b1;
        tick();
        fw_dat_valid_i = 1'b0;
    endtask

    task automatic finish_mark();
        mk_q.push_back({~m_bank, m_cnt[AW:0]});
        m_bank = ~m_bank;
        m_cnt  = 0;
        m_wait = 1'b0;
    endtask

    task automatic do_mark(input logic with_byte, input logic [7:0] d, output int c_req);
        if (with_byte) begin
            push_byte(d);
            fw_dat_i       = d;
            fw_dat_valid_i = 1'b1;
        end
        fw_mark_req_i = 1'b1;
        tick();
        fw_mark_req_i  = 1'b0;
        fw_dat_valid_i = 1'b0;
        c_req = cyc;
        if (m_cnt > 0 && !m_wait) begin
            if (!fw_pending_i) finish_mark();
            else m_wait = 1'b1;
        end
    endtask

    initial begin
        int c_req;
        int base;

        // reset state
        do_reset();
        @(negedge sysclk_i);
        check_val("rst_we", {31'd0, bram_we_o}, 0);
        check_val("rst_addr", {19'd0, bram_addr_o}, 0);
        check_val("rst_bank", {31'd0, fw_bank_o}, 0);
        check_val("rst_len", {19'd0, fw_len_o}, 0);
        check_val("rst_flags", {30'd0, fw_overflow_o, fw_markerr_o}, 0);
        tick();

        // five bytes into bank 0
        base = wr_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        repeat (2) tick();
        check_val("t1_wr_count", wr_cnt - base, 5);

        // mark with pending low: pulse two cycles after the request
        base = mark_cnt;
        do_mark(1'b0, 8'h00, c_req);
        repeat (3) tick();
        check_val("t2_mark_count", mark_cnt - base, 1);
        check_val("t2_mark_latency", last_mark_cyc, c_req + 1);
        check_val("t2_len", {19'd0, fw_len_o}, 5);
        check_val("t2_bank", {31'd0, fw_bank_o}, 1);
        send_byte(8'h55);
        @(negedge sysclk_i);
        check_val("t2_addr_bank1", {19'd0, bram_addr_o}, 32'h1000);
        tick();

        // mark held off while the PS still owns the previous bank
        fw_pending_i = 1'b1;
        base = mark_cnt;
        do_mark(1'b0, 8'h00, c_req);
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        check_val("t3_no_mark", mark_cnt - base, 0);
        check_val("t3_overflow", {31'd0, fw_overflow_o}, 1);
        fw_pending_i = 1'b0;
        finish_mark();
        repeat (4) tick();
        check_val("t3_mark_count", mark_cnt - base, 1);
        check_val("t3_bank", {31'd0, fw_bank_o}, 0);

        // fill a whole bank, then one byte too many
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i * 7));
        tick();
        check_val("t4_no_overflow_full", {31'd0, fw_overflow_o}, 0);
        base = wr_cnt;
        send_byte(8'hEE);
        repeat (2) tick();
        check_val("t4_extra_not_written", wr_cnt - base, 0);
        check_val("t4_overflow", {31'd0, fw_overflow_o}, 1);
        do_mark(1'b0, 8'h00, c_req);
        repeat (3) tick();
        check_val("t4_len_full", {19'd0, fw_len_o}, DEPTH);

        // mark on an empty bank, then byte and mark in the same cycle
        do_reset();
        base = mark_cnt;
        do_mark(1'b0, 8'h00, c_req);
        repeat (4) tick();
        check_val("t5_markerr", {31'd0, fw_markerr_o}, 1);
        check_val("t5_no_mark", mark_cnt - base, 0);
        do_mark(1'b1, 8'h3C, c_req);
        repeat (4) tick();
        check_val("t5_mark_count", mark_cnt - base, 1);
        check_val("t5_len_one", {19'd0, fw_len_o}, 1);

        // reset while waiting for the PS discards the pending mark
        send_byte(8'h77);
        fw_pending_i = 1'b1;
        base = mark_cnt;
        do_mark(1'b0, 8'h00, c_req);
        repeat (3) tick();
        #2 sysrst_n_i = 1'b0;
        #1;
        check_val("t6_rst_bank", {31'd0, fw_bank_o}, 0);
        check_val("t6_rst_len", {19'd0, fw_len_o}, 0);
        check_val("t6_rst_flags", {30'd0, fw_overflow_o, fw_markerr_o}, 0);
        check_val("t6_rst_pulses", {29'd0, bram_we_o, fw_wr_o, fw_mark_o}, 0);
        model_clear();
        tick();
        sysrst_n_i   = 1'b1;
        fw_pending_i = 1'b0;
        repeat (10) tick();
        check_val("t6_no_mark", mark_cnt - base, 0);
        send_byte(8'h99);
        repeat (2) tick();

        check_val("end_wr_q_empty", wr_q.size(), 0);
        check_val("end_mk_q_empty", mk_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
